// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle restoring divider, one quotient bit per
// clock through a single W+1-bit trial subtraction.
//
// Handshake: start is sampled only in IDLE; the edge that samples start=1 is
// the accepting edge and also captures dividend/divisor. busy is high for the
// whole operation (CALC and DONE), done is a one-cycle pulse in DONE, and
// quotient/remainder/div_by_zero are registered on the edge entering DONE and
// held until the next one. start is ignored while busy (no queuing).
//
// Optional build macro: SIGNED_DIV_EN selects two's complement operands
// (quotient truncates toward zero, remainder takes the dividend's sign).
// Without it the divider is purely unsigned and carries no sign logic.
module seq_restoring_divider #(
  parameter int W = 32,
  localparam int CW = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Working registers. The restored partial remainder is always below the
  // divisor, so its top bit of the W+1-bit datapath is always zero and only
  // W bits need storing; the extra bit lives in the trial subtraction.
  logic [W-1:0]  r_reg;
  logic [W-1:0]  q_reg;
  logic [W-1:0]  d_reg;
  logic [CW-1:0] cnt;

  logic          accept;
  logic          zero_div;
  logic          last_step;
  logic [W:0]    shifted;
  logic [W:0]    trial;
  logic [W-1:0]  r_next;
  logic [W-1:0]  q_next;
  logic [W-1:0]  load_a;
  logic [W-1:0]  load_b;
  logic [W-1:0]  q_final;
  logic [W-1:0]  r_final;

  assign accept    = (state == S_IDLE) && start;
  assign zero_div  = (divisor == '0);
  assign last_step = (state == S_CALC) && (cnt == CW'(W - 1));

  // One restoring step: shift in the next dividend bit, try subtracting D,
  // keep the difference only if it did not go negative.
  assign shifted = {r_reg, q_reg[W-1]};
  assign trial   = shifted - {1'b0, d_reg};
  assign r_next  = trial[W] ? shifted[W-1:0] : trial[W-1:0];
  assign q_next  = {q_reg[W-2:0], ~trial[W]};

`ifdef SIGNED_DIV_EN
  // Result signs captured at accept; magnitudes go through the unsigned core.
  logic q_neg;
  logic r_neg;

  // The most-negative value maps onto itself, which as an unsigned magnitude
  // is exactly 2^(W-1); this makes most-negative / -1 come out as
  // most-negative with zero remainder without a special case.
  assign load_a  = dividend[W-1] ? (~dividend + 1'b1) : dividend;
  assign load_b  = divisor[W-1]  ? (~divisor + 1'b1)  : divisor;
  assign q_final = q_neg ? (~q_next + 1'b1) : q_next;
  assign r_final = r_neg ? (~r_next + 1'b1) : r_next;

  // Capture the result signs on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (accept && !zero_div) begin
      q_neg <= dividend[W-1] ^ divisor[W-1];
      r_neg <= dividend[W-1];
    end
  end
`else
  assign load_a  = dividend;
  assign load_b  = divisor;
  assign q_final = q_next;
  assign r_final = r_next;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state decode: zero divisor skips CALC entirely.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = zero_div ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (last_step) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Iteration datapath: load operands on accept, step once per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg <= '0;
      q_reg <= '0;
      d_reg <= '0;
      cnt   <= '0;
    end else if (accept && !zero_div) begin
      r_reg <= '0;
      q_reg <= load_a;
      d_reg <= load_b;
      cnt   <= '0;
    end else if (state == S_CALC) begin
      r_reg <= r_next;
      q_reg <= q_next;
      cnt   <= cnt + CW'(1);
    end
  end

  // Result registers: written only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept && zero_div) begin
      quotient    <= '1;
      remainder   <= dividend;
      div_by_zero <= 1'b1;
    end else if (last_step) begin
      quotient    <= q_final;
      remainder   <= r_final;
      div_by_zero <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed vectors for the restoring divider at
// W=8 (main handshake, zero divisor, start held, reset mid-operation, and the
// signed cases when SIGNED_DIV_EN is defined) and at W=32 (all-ones / 1).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seq_restoring_divider;

  logic        clk;
  logic        rst_n;

  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [7:0]  q8;
  logic [7:0]  r8;
  logic        z8;

  logic        start32;
  logic [31:0] a32;
  logic [31:0] b32;
  logic        busy32;
  logic        done32;
  logic [31:0] q32;
  logic [31:0] r32;
  logic        z32;

  int checks = 0;
  int errors = 0;

  seq_restoring_divider #(.W(8)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start8),
    .dividend    (a8),
    .divisor     (b8),
    .busy        (busy8),
    .done        (done8),
    .quotient    (q8),
    .remainder   (r8),
    .div_by_zero (z8)
  );

  seq_restoring_divider #(.W(32)) dut32 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start32),
    .dividend    (a32),
    .divisor     (b32),
    .busy        (busy32),
    .done        (done32),
    .quotient    (q32),
    .remainder   (r32),
    .div_by_zero (z32)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present operands with start=1; the next rising edge accepts them.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    a8     = a;
    b8     = b;
    start8 = 1'b1;
  endtask

  // Follow one operation from the falling edge after its accepting edge until
  // busy drops. lat is the falling-edge index (1 = first after accept) where
  // done was first seen. With hold=1, start stays high and the operands are
  // switched to 9/3 right after accept.
  task automatic follow8(input bit hold, output int lat, output int busy_n,
                         output int done_n, output logic [31:0] q,
                         output logic [31:0] r, output logic [31:0] z);
    lat = 0; busy_n = 0; done_n = 0; q = '0; r = '0; z = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (hold) begin
          a8 = 8'd9;
          b8 = 8'd3;
        end else begin
          start8 = 1'b0;
        end
      end
      if (busy8) busy_n++;
      if (done8) begin
        done_n++;
        if (done_n == 1) lat = i + 1;
        q = {24'd0, q8};
        r = {24'd0, r8};
        z = {31'd0, z8};
      end
      if (!busy8) break;
    end
  endtask

  task automatic check_op8(input string tag, input bit hold, input logic [7:0] eq,
                           input logic [7:0] er, input logic ez, input int elat);
    int lat, busy_n, done_n;
    logic [31:0] q, r, z;
    follow8(hold, lat, busy_n, done_n, q, r, z);
    check({tag, ".latency"}, lat, elat);
    check({tag, ".busy_cycles"}, busy_n, elat);
    check({tag, ".done_pulses"}, done_n, 1);
    check({tag, ".quotient"}, q, {24'd0, eq});
    check({tag, ".remainder"}, r, {24'd0, er});
    check({tag, ".div_by_zero"}, z, {31'd0, ez});
  endtask

  initial begin
    int lat32;
    int done32_n;

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start32 = 1'b0; a32 = '0; b32 = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset.busy8", busy8, 0);
    check("reset.done8", done8, 0);
    check("reset.q8", q8, 0);
    check("reset.r8", r8, 0);
    check("reset.z8", z8, 0);
    check("reset.busy32", busy32, 0);
    check("reset.q32", q32, 0);
    rst_n = 1'b1;

    // Basic operation and zero divisor followed by a normal one.
    launch8(8'd100, 8'd7);
    check_op8("u100_7", 1'b0, 8'd14, 8'd2, 1'b0, 9);
    launch8(8'd55, 8'd0);
    check_op8("u55_0", 1'b0, 8'hFF, 8'd55, 1'b1, 1);
    launch8(8'd200, 8'd10);
`ifdef SIGNED_DIV_EN
    check_op8("s200_10", 1'b0, 8'hFB, 8'hFA, 1'b0, 9);
`else
    check_op8("u200_10", 1'b0, 8'd20, 8'd0, 1'b0, 9);
`endif
    launch8(8'd0, 8'd5);
    check_op8("u0_5", 1'b0, 8'd0, 8'd0, 1'b0, 9);

    // start held with changed operands: one done, then 9/3 in the next IDLE.
    launch8(8'd255, 8'd16);
`ifdef SIGNED_DIV_EN
    check_op8("s255_16_hold", 1'b1, 8'h00, 8'hFF, 1'b0, 9);
`else
    check_op8("u255_16_hold", 1'b1, 8'd15, 8'd15, 1'b0, 9);
`endif
    check_op8("u9_3_next", 1'b0, 8'd3, 8'd0, 1'b0, 9);

    // Reset in the middle of an operation.
    launch8(8'd100, 8'd7);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset.busy", busy8, 0);
    check("midreset.done", done8, 0);
    check("midreset.quotient", q8, 0);
    check("midreset.remainder", r8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    launch8(8'd3, 8'd5);
    check_op8("u3_5_after_reset", 1'b0, 8'd0, 8'd3, 1'b0, 9);

`ifdef SIGNED_DIV_EN
    launch8(8'h9C, 8'd7);            // -100 / 7
    check_op8("s_m100_7", 1'b0, 8'hF2, 8'hFE, 1'b0, 9);
    launch8(8'h80, 8'hFF);           // -128 / -1
    check_op8("s_m128_m1", 1'b0, 8'h80, 8'h00, 1'b0, 9);
    launch8(8'd100, 8'hF9);          // 100 / -7
    check_op8("s100_m7", 1'b0, 8'hF2, 8'h02, 1'b0, 9);
    launch8(8'hF9, 8'd0);            // -7 / 0
    check_op8("s_m7_0", 1'b0, 8'hFF, 8'hF9, 1'b1, 1);
`endif

    // W=32: all ones divided by one, done on falling edge 33 after accept.
    @(negedge clk);
    a32 = 32'hFFFF_FFFF;
    b32 = 32'd1;
    start32 = 1'b1;
    lat32 = 0;
    done32_n = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (i == 0) start32 = 1'b0;
      if (done32) begin
        done32_n++;
        if (done32_n == 1) lat32 = i + 1;
      end
      if (!busy32) break;
    end
    check("w32.latency", lat32, 33);
    check("w32.done_pulses", done32_n, 1);
    check("w32.quotient", q32, 32'hFFFF_FFFF);
    check("w32.remainder", r32, 32'd0);
    check("w32.div_by_zero", z32, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
